lsu_dccm_mem_bw: RTL and testbench
==================================

# lsu_dccm_mem_bw

Parametrised successor to the LSU DCCM bank array: N single-ported banks addressed by a lo/hi pair, so an unaligned access can span two banks. It adds byte-strobed writes via an internal read-modify-write sequence, a valid/ready request handshake, and a registered read-response valid. It sits between the LSU DC1/DC2 address/data path and the bank SRAMs.

## Interface
- DCCM_BYTE_WIDTH, 4: bytes per bank word (power of two); data width W = 8*DCCM_BYTE_WIDTH.
- DCCM_NUM_BANKS, 4: bank count (power of two, ≥2); DCCM_BANK_BITS = log2.
- DCCM_INDEX_DEPTH, 1024: words per bank (power of two).
- DCCM_BITS, derived: log2(DCCM_BYTE_WIDTH*DCCM_NUM_BANKS*DCCM_INDEX_DEPTH), byte address width.
- clk  in  1  clock.
- rst_l  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr_lo / req_addr_hi  in  DCCM_BITS each  byte addresses of lo and hi words.
- req_wdata_lo / req_wdata_hi  in  W each  write data.
- req_wstrb_lo / req_wstrb_hi  in  DCCM_BYTE_WIDTH each  byte enables.
- rsp_valid  out  1  read data valid.
- rsp_rdata_lo / rsp_rdata_hi  out  W each  read data.

## Operation
- Address split: offset [log2(BYTE_WIDTH)-1:0], bank = next DCCM_BANK_BITS, index = remaining upper bits.
- Unaligned: bank(lo) != bank(hi). Aligned: hi is ignored and lo-side data/strobe drive the access; rsp_rdata_hi = rsp_rdata_lo.
- Bank select and routing are as in the existing DCCM: bank i is enabled if bank(lo)==i or bank(hi)==i. Bank(hi) takes hi index/data/strobe when unaligned; every other enabled bank takes lo.
- Per bank side, a write is full if its strobe is all-ones and partial if it is not all-ones and not zero. A zero strobe means no write on that side.
- FSM states: IDLE and RMW.
  - IDLE: req_ready=1.
  - Accepted read: enabled banks read; stay in IDLE.
  - Accepted write, every enabled side full or zero: single-cycle write; stay in IDLE.
  - Accepted write, any side partial: enabled banks are read (not written) and the address, data and strobes are captured; go to RMW.
- RMW: req_ready=0. Each side is merged per byte: strobe bit ? new byte : old byte. Full sides write captured data directly. The merged words are written; go to IDLE unconditionally.
- Reads never return merged or forwarded data. Read-after-write ordering holds because the port is single and sequential.
- Memory contents are not initialised by reset.

## Timing
- Read accepted at edge T: data is presented at edge T+1 with rsp_valid=1 for exactly one cycle. The data is held until the next read response (rsp_rdata registered/held).
- Full write: occupies one cycle; back-to-back requests are accepted every cycle.
- Partial write: occupies two cycles; req_ready is low for the single cycle after acceptance.
- Reset values: state=IDLE, req_ready=1 (in the reset cycle too), rsp_valid=0, rsp_rdata_lo/hi=0, captured RMW registers=0.
- Reset asserted while in RMW: the pending merge-write is dropped and no bank is written on that edge. Data already written is retained.
- Top-of-memory wrap: hi address wrapping to bank 0, index 0 is legal. Routing is purely by decoded bank/index.
- req_valid high while req_ready low: the request is held by the master and not sampled. No bank is touched by it.
- Strobes are ignored on reads.

## Structure
- Package lsu_dccm_pkg: state enum (IDLE, RMW); a function that decodes bank/index/offset from DCCM_BITS-wide addresses; a byte-merge function (old, new, strobe).
- Sub-module lsu_dccm_bank: one 1RW synchronous-read bank. Ports: clk, me, we, adr[log2(DEPTH)-1:0], d[W-1:0], q[W-1:0]. The q output holds its value when me=0. Instantiate DCCM_NUM_BANKS copies in a generate loop; the macro SRAM substitution goes in this sub-module only.
- Top holds routing, FSM, RMW capture registers, the registered lo/hi bank selects for the response mux, and rsp_valid.

## Test plan
- Reset, then aligned full write 0xDEADBEEF to 0x100, then read 0x100: rsp_valid at T+1, lo=hi=0xDEADBEEF, req_ready constantly 1.
- Partial write to 0x100 with wstrb_lo=4'b0010, wdata=0x0000AA00: req_ready low for 1 cycle. A following read returns 0xDEADAAEF.
- Unaligned write with lo=0x10E (bank 3) and hi=0x110 (bank 0, index+1), both full, with data 0x11111111/0x22222222. A read at the same pair returns lo=0x11111111, hi=0x22222222; a single read at 0x110 returns 0x22222222.
- Unaligned partial write, lo strobe 4'b1000 and hi strobe 4'b0001: exactly the two targeted bytes change and the neighbouring bytes in both banks are preserved.
- Reset asserted in the RMW cycle of a partial write to 0x200 (prior value 0x12345678): a read after reset returns 0x12345678, and rsp_valid=0 during reset.
- Top-address wrap: lo = last word of bank 3, hi = index 0 of bank 0. Write and read back a distinct pattern. Confirm hi is routed to bank 0, index 0, and that all other banks are unchanged.

Source files
------------

// File: rtl/lsu_dccm_mem_bw_pkg.sv
//------------------------------------------------------------------------------
// lsu_dccm_pkg : shared types and helpers for the banked DCCM array
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lsu_dccm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } dccm_state_e;

    // Fields are wide enough for any legal configuration; callers slice them down.
    typedef struct packed {
        logic [31:0] index;
        logic [31:0] bank;
        logic [31:0] offset;
    } dccm_addr_t;

    function automatic dccm_addr_t dccm_decode(input logic [31:0] addr,
                                               input int unsigned off_bits,
                                               input int unsigned bank_bits);
        dccm_addr_t dec;
        dec.offset = addr & ((32'd1 << off_bits) - 32'd1);
        dec.bank   = (addr >> off_bits) & ((32'd1 << bank_bits) - 32'd1);
        dec.index  = addr >> (off_bits + bank_bits);
        return dec;
    endfunction

    // Byte merge for words of up to 8 bytes: strobe bit selects the new byte.
    function automatic logic [63:0] dccm_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_dccm_mem_bw_if.sv
//------------------------------------------------------------------------------
// lsu_dccm_mem_bw_if : request/response bus between LSU and DCCM bank array
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_dccm_mem_bw_if #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STRB_W    = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr_lo;
    logic [ADDR_BITS-1:0] req_addr_hi;
    logic [DATA_W-1:0]    req_wdata_lo;
    logic [DATA_W-1:0]    req_wdata_hi;
    logic [STRB_W-1:0]    req_wstrb_lo;
    logic [STRB_W-1:0]    req_wstrb_hi;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_rdata_lo;
    logic [DATA_W-1:0]    rsp_rdata_hi;

    modport master (
        output req_valid, req_write, req_addr_lo, req_addr_hi,
               req_wdata_lo, req_wdata_hi, req_wstrb_lo, req_wstrb_hi,
        input  req_ready, rsp_valid, rsp_rdata_lo, rsp_rdata_hi
    );

    modport slave (
        input  req_valid, req_write, req_addr_lo, req_addr_hi,
               req_wdata_lo, req_wdata_hi, req_wstrb_lo, req_wstrb_hi,
        output req_ready, rsp_valid, rsp_rdata_lo, rsp_rdata_hi
    );
endinterface

`default_nettype wire

// File: rtl/lsu_dccm_mem_bw_bank.sv
//------------------------------------------------------------------------------
// lsu_dccm_bank : one 1RW synchronous-read bank; swap in the SRAM macro here
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dccm_bank #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          me,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q;

    // q only moves on a read, so it holds across idle and write cycles.
    always_ff @(posedge clk) begin
        if (me) begin
            if (we) r_mem[adr] <= d;
            else    r_q        <= r_mem[adr];
        end
    end

    assign q = r_q;
endmodule

`default_nettype wire

// File: rtl/lsu_dccm_mem_bw.sv
//------------------------------------------------------------------------------
// lsu_dccm_mem_bw : banked DCCM with lo/hi routing and byte-strobe RMW writes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dccm_mem_bw
    import lsu_dccm_pkg::*;
#(
    parameter int unsigned DCCM_BYTE_WIDTH  = 4,
    parameter int unsigned DCCM_NUM_BANKS   = 4,
    parameter int unsigned DCCM_INDEX_DEPTH = 1024,
    parameter int unsigned DCCM_BITS        = $clog2(DCCM_BYTE_WIDTH*DCCM_NUM_BANKS*DCCM_INDEX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_l,
    lsu_dccm_mem_bw_if.slave bus
);
    localparam int unsigned W              = 8 * DCCM_BYTE_WIDTH;
    localparam int unsigned OFF_BITS       = $clog2(DCCM_BYTE_WIDTH);
    localparam int unsigned DCCM_BANK_BITS = $clog2(DCCM_NUM_BANKS);
    localparam int unsigned IDX_BITS       = $clog2(DCCM_INDEX_DEPTH);

    dccm_state_e               r_state;
    dccm_addr_t                w_dec_lo, w_dec_hi;
    logic [DCCM_BANK_BITS-1:0] w_bank_lo, w_bank_hi;
    logic [IDX_BITS-1:0]       w_idx_lo, w_idx_hi;
    logic                      w_unal, w_part_lo, w_part_hi, w_partial, w_ready;
    logic                      w_unused_dec;

    logic                       r_cap_unal;
    logic [DCCM_BANK_BITS-1:0]  r_cap_bank_lo, r_cap_bank_hi;
    logic [IDX_BITS-1:0]        r_cap_idx_lo, r_cap_idx_hi;
    logic [W-1:0]               r_cap_wdata_lo, r_cap_wdata_hi;
    logic [DCCM_BYTE_WIDTH-1:0] r_cap_wstrb_lo, r_cap_wstrb_hi;

    logic                      r_rsp_valid;
    logic [DCCM_BANK_BITS-1:0] r_sel_lo, r_sel_hi;
    logic [W-1:0]              r_hold_lo, r_hold_hi, w_q_lo, w_q_hi;

    logic [DCCM_NUM_BANKS-1:0] w_me, w_we;
    logic [IDX_BITS-1:0]       w_adr [DCCM_NUM_BANKS];
    logic [W-1:0]              w_d   [DCCM_NUM_BANKS];
    logic [W-1:0]              w_q   [DCCM_NUM_BANKS];

    assign w_dec_lo  = dccm_decode(32'(bus.req_addr_lo), OFF_BITS, DCCM_BANK_BITS);
    assign w_dec_hi  = dccm_decode(32'(bus.req_addr_hi), OFF_BITS, DCCM_BANK_BITS);
    assign w_bank_lo = w_dec_lo.bank[DCCM_BANK_BITS-1:0];
    assign w_bank_hi = w_dec_hi.bank[DCCM_BANK_BITS-1:0];
    assign w_idx_lo  = w_dec_lo.index[IDX_BITS-1:0];
    assign w_idx_hi  = w_dec_hi.index[IDX_BITS-1:0];
    assign w_unused_dec = ^{w_dec_lo.offset, w_dec_lo.bank[31:DCCM_BANK_BITS], w_dec_lo.index[31:IDX_BITS],
                            w_dec_hi.offset, w_dec_hi.bank[31:DCCM_BANK_BITS], w_dec_hi.index[31:IDX_BITS]};

    assign w_unal    = (w_bank_lo != w_bank_hi);
    assign w_part_lo = (bus.req_wstrb_lo != '0) && !(&bus.req_wstrb_lo);
    assign w_part_hi = (bus.req_wstrb_hi != '0) && !(&bus.req_wstrb_hi);
    assign w_partial = w_part_lo || (w_unal && w_part_hi);
    assign w_ready   = !rst_l || (r_state == ST_IDLE);

    // Bank routing: bank(hi) takes the hi side only when unaligned; everything else takes lo.
    always_comb begin : c_route
        logic                       hi_sel;
        logic                       en;
        logic [DCCM_BYTE_WIDTH-1:0] strb;
        w_me = '0;
        w_we = '0;
        for (int i = 0; i < DCCM_NUM_BANKS; i++) begin
            hi_sel   = 1'b0;
            en       = 1'b0;
            strb     = '0;
            w_adr[i] = '0;
            w_d[i]   = '0;
            if (r_state == ST_IDLE) begin
                hi_sel   = w_unal && (w_bank_hi == DCCM_BANK_BITS'(i));
                en       = hi_sel || (w_bank_lo == DCCM_BANK_BITS'(i));
                w_adr[i] = hi_sel ? w_idx_hi : w_idx_lo;
                w_d[i]   = hi_sel ? bus.req_wdata_hi : bus.req_wdata_lo;
                strb     = hi_sel ? bus.req_wstrb_hi : bus.req_wstrb_lo;
                if (bus.req_valid && en) begin
                    if (!bus.req_write || w_partial) begin
                        w_me[i] = 1'b1;
                    end else if (strb != '0) begin
                        w_me[i] = 1'b1;
                        w_we[i] = 1'b1;
                    end
                end
            end else begin
                hi_sel   = r_cap_unal && (r_cap_bank_hi == DCCM_BANK_BITS'(i));
                en       = hi_sel || (r_cap_bank_lo == DCCM_BANK_BITS'(i));
                w_adr[i] = hi_sel ? r_cap_idx_hi : r_cap_idx_lo;
                strb     = hi_sel ? r_cap_wstrb_hi : r_cap_wstrb_lo;
                w_d[i]   = W'(dccm_merge(64'(w_q[i]), 64'(hi_sel ? r_cap_wdata_hi : r_cap_wdata_lo), 8'(strb)));
                if (en && (strb != '0)) begin
                    w_me[i] = 1'b1;
                    w_we[i] = 1'b1;
                end
            end
            if (!rst_l) begin
                w_me[i] = 1'b0;
                w_we[i] = 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < DCCM_NUM_BANKS; g++) begin : g_bank
            lsu_dccm_bank #(
                .W     (W),
                .DEPTH (DCCM_INDEX_DEPTH)
            ) u_bank (
                .clk (clk),
                .me  (w_me[g]),
                .we  (w_we[g]),
                .adr (w_adr[g]),
                .d   (w_d[g]),
                .q   (w_q[g])
            );
        end
    endgenerate

    assign w_q_lo = w_q[r_sel_lo];
    assign w_q_hi = w_q[r_sel_hi];

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state        <= ST_IDLE;
            r_rsp_valid    <= 1'b0;
            r_sel_lo       <= '0;
            r_sel_hi       <= '0;
            r_hold_lo      <= '0;
            r_hold_hi      <= '0;
            r_cap_unal     <= 1'b0;
            r_cap_bank_lo  <= '0;
            r_cap_bank_hi  <= '0;
            r_cap_idx_lo   <= '0;
            r_cap_idx_hi   <= '0;
            r_cap_wdata_lo <= '0;
            r_cap_wdata_hi <= '0;
            r_cap_wstrb_lo <= '0;
            r_cap_wstrb_hi <= '0;
        end else begin
            // Bank q may be overwritten by a later RMW read, so latch the response.
            if (r_rsp_valid) begin
                r_hold_lo <= w_q_lo;
                r_hold_hi <= w_q_hi;
            end
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (!bus.req_write) begin
                            r_rsp_valid <= 1'b1;
                            r_sel_lo    <= w_bank_lo;
                            r_sel_hi    <= w_unal ? w_bank_hi : w_bank_lo;
                        end else if (w_partial) begin
                            r_state        <= ST_RMW;
                            r_cap_unal     <= w_unal;
                            r_cap_bank_lo  <= w_bank_lo;
                            r_cap_bank_hi  <= w_bank_hi;
                            r_cap_idx_lo   <= w_idx_lo;
                            r_cap_idx_hi   <= w_idx_hi;
                            r_cap_wdata_lo <= bus.req_wdata_lo;
                            r_cap_wdata_hi <= bus.req_wdata_hi;
                            r_cap_wstrb_lo <= bus.req_wstrb_lo;
                            r_cap_wstrb_hi <= bus.req_wstrb_hi;
                        end
                    end
                end
                ST_RMW:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata_lo = r_rsp_valid ? w_q_lo : r_hold_lo;
    assign bus.rsp_rdata_hi = r_rsp_valid ? w_q_hi : r_hold_hi;
endmodule

`default_nettype wire

// File: tb/tb_lsu_dccm_mem_bw.sv
//------------------------------------------------------------------------------
// tb_lsu_dccm_mem_bw : directed scoreboard bench for lsu_dccm_mem_bw
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dccm_mem_bw;
    logic clk = 1'b0;
    logic rst_l;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lsu_dccm_mem_bw_if #(.ADDR_BITS(14), .DATA_W(32), .STRB_W(4)) bus ();

    lsu_dccm_mem_bw dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_model [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return m;
    endfunction

    function automatic logic is_partial(input logic [3:0] s);
        return (s != 4'h0) && (s != 4'hF);
    endfunction

    // Response monitor: every response must match the oldest outstanding read.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            exp_t e;
            check("sb nonempty at rsp", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, " lo"}, 64'(bus.rsp_rdata_lo), 64'(e.lo));
                check({e.tag, " hi"}, 64'(bus.rsp_rdata_hi), 64'(e.hi));
            end
        end
    end

    // Drive a request at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic wr, input logic [13:0] al, input logic [13:0] ah,
                          input logic [31:0] dl, input logic [31:0] dh,
                          input logic [3:0] sl, input logic [3:0] sh);
        int budget = 0;
        bus.req_write    = wr;
        bus.req_addr_lo  = al;
        bus.req_addr_hi  = ah;
        bus.req_wdata_lo = dl;
        bus.req_wdata_hi = dh;
        bus.req_wstrb_lo = sl;
        bus.req_wstrb_hi = sh;
        bus.req_valid    = 1'b1;
        while (bus.req_ready !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready before accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic model_write(input logic [13:0] al, input logic [13:0] ah,
                               input logic [31:0] dl, input logic [31:0] dh,
                               input logic [3:0] sl, input logic [3:0] sh);
        int kl = int'(al >> 2);
        int kh = int'(ah >> 2);
        if (sl != 4'h0) mem_model[kl] = merge32(mem_model.exists(kl) ? mem_model[kl] : 32'h0, dl, sl);
        if (al[3:2] != ah[3:2] && sh != 4'h0)
            mem_model[kh] = merge32(mem_model.exists(kh) ? mem_model[kh] : 32'h0, dh, sh);
    endtask

    task automatic wr_req(input logic [13:0] al, input logic [13:0] ah,
                          input logic [31:0] dl, input logic [31:0] dh,
                          input logic [3:0] sl, input logic [3:0] sh, input string tag);
        logic part;
        part = is_partial(sl) || ((al[3:2] != ah[3:2]) && is_partial(sh));
        do_req(1'b1, al, ah, dl, dh, sl, sh);
        model_write(al, ah, dl, dh, sl, sh);
        check({tag, " ready after accept"}, 64'(bus.req_ready), 64'(!part));
        if (part) begin
            @(negedge clk);
            check({tag, " ready after rmw"}, 64'(bus.req_ready), 64'd1);
        end
    endtask

    task automatic rd_req(input logic [13:0] al, input logic [13:0] ah, input string tag);
        exp_t e;
        e.lo  = mem_model[int'(al >> 2)];
        e.hi  = (al[3:2] != ah[3:2]) ? mem_model[int'(ah >> 2)] : e.lo;
        e.tag = tag;
        sb.push_back(e);
        do_req(1'b0, al, ah, 32'h0, 32'h0, 4'hF, 4'hF);
        check({tag, " rsp_valid at T+1"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    initial begin
        logic [13:0] wrap_addrs [8];
        wrap_addrs = '{14'h3FF0, 14'h3FF4, 14'h3FF8, 14'h3FFC, 14'h0000, 14'h0004, 14'h0008, 14'h000C};

        rst_l            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr_lo  = '0;
        bus.req_addr_hi  = '0;
        bus.req_wdata_lo = '0;
        bus.req_wdata_hi = '0;
        bus.req_wstrb_lo = '0;
        bus.req_wstrb_hi = '0;
        repeat (3) @(negedge clk);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset rdata_lo", 64'(bus.rsp_rdata_lo), 64'd0);
        check("reset rdata_hi", 64'(bus.rsp_rdata_hi), 64'd0);
        check("reset req_ready", 64'(bus.req_ready), 64'd1);
        rst_l = 1'b1;
        @(negedge clk);

        // Aligned full write then read
        wr_req(14'h100, 14'h100, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, "full wr 0x100");
        rd_req(14'h100, 14'h100, "rd 0x100");
        @(negedge clk);
        check("rsp_valid single cycle", 64'(bus.rsp_valid), 64'd0);

        // Partial write; a request offered during RMW must not be sampled
        wr_req(14'h104, 14'h104, 32'h0BADF00D, 32'h0, 4'hF, 4'h0, "full wr 0x104");
        do_req(1'b1, 14'h100, 14'h100, 32'h0000AA00, 32'h0, 4'b0010, 4'h0);
        model_write(14'h100, 14'h100, 32'h0000AA00, 32'h0, 4'b0010, 4'h0);
        check("partial ready low", 64'(bus.req_ready), 64'd0);
        bus.req_write = 1'b1; bus.req_addr_lo = 14'h104; bus.req_addr_hi = 14'h104;
        bus.req_wdata_lo = 32'hFFFFFFFF; bus.req_wstrb_lo = 4'hF; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("partial ready back", 64'(bus.req_ready), 64'd1);
        rd_req(14'h100, 14'h100, "rd merged 0x100");
        rd_req(14'h104, 14'h104, "rd 0x104 untouched");
        repeat (2) @(negedge clk);
        check("hold rdata_lo", 64'(bus.rsp_rdata_lo), 64'h0BADF00D);
        check("hold rsp_valid", 64'(bus.rsp_valid), 64'd0);

        // Unaligned full write across banks 3/0, then back-to-back reads
        wr_req(14'h10E, 14'h110, 32'h11111111, 32'h22222222, 4'hF, 4'hF, "unal full wr");
        rd_req(14'h10E, 14'h110, "rd unal pair");
        rd_req(14'h110, 14'h110, "rd 0x110");

        // Unaligned partial write touches exactly one byte per side
        wr_req(14'h10E, 14'h110, 32'hCCCCCCCC, 32'h33333333, 4'b1000, 4'b0001, "unal partial wr");
        rd_req(14'h10E, 14'h110, "rd unal partial");
        check("model lo byte merge", 64'(mem_model[int'(14'h10E >> 2)]), 64'hCC111111);

        // Reset during the RMW cycle drops the merge-write
        wr_req(14'h200, 14'h200, 32'h12345678, 32'h0, 4'hF, 4'h0, "full wr 0x200");
        rd_req(14'h200, 14'h200, "rd 0x200 before");
        do_req(1'b1, 14'h200, 14'h200, 32'h000000FF, 32'h0, 4'b0001, 4'h0);
        rst_l = 1'b0;
        #1;
        check("ready in rmw reset", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        check("rsp_valid in reset", 64'(bus.rsp_valid), 64'd0);
        check("rdata_lo in reset", 64'(bus.rsp_rdata_lo), 64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        rd_req(14'h200, 14'h200, "rd 0x200 after rst");

        // Top-of-memory wrap: bank 3 last index pairs with bank 0 index 0
        for (int i = 0; i < 8; i++)
            wr_req(wrap_addrs[i], wrap_addrs[i], 32'hA0A0A0A0 + 32'(i) * 32'h01010101, 32'h0,
                   4'hF, 4'h0, "wrap preload");
        wr_req(14'h3FFC, 14'h0000, 32'h5A5A1234, 32'hC3C35678, 4'hF, 4'hF, "wrap wr");
        rd_req(14'h3FFC, 14'h0000, "rd wrap pair");
        for (int i = 0; i < 8; i++)
            rd_req(wrap_addrs[i], wrap_addrs[i], $sformatf("rd wrap word %0d", i));
        check("wrap hi at bank0 idx0", 64'(mem_model[0]), 64'hC3C35678);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
